// File: rtl/fft_axil_frame_ctrl_if.sv
// fft_axil_frame_ctrl_if: AXI4-Lite slave channel bundle for the FFT frame controller
interface fft_axil_frame_ctrl_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                      awprot;
    logic                            awvalid;
    logic                            awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                            wvalid;
    logic                            wready;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                      arprot;
    logic                            arvalid;
    logic                            arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      rresp;
    logic                            rvalid;
    logic                            rready;
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/fft_axil_frame_ctrl.sv
// fft_axil_frame_ctrl: AXI4-Lite register/buffer front end streaming one frame through the FFT core
module fft_axil_frame_ctrl #(
    parameter int WL                 = 16,
    parameter int N_PTS              = 16,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_aresetn,
    fft_axil_frame_ctrl_if.slave s_axi,
    output logic                 fft_in_valid,
    input  logic                 fft_in_ready,
    output logic [2*WL-1:0]      fft_in_data,
    output logic                 fft_in_last,
    input  logic                 fft_out_valid,
    output logic                 fft_out_ready,
    input  logic [2*WL-1:0]      fft_out_data,
    input  logic                 fft_out_last,
    output logic                 irq
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int IW = $clog2(N_PTS);
    localparam int NB = DW / 8;
    localparam logic [IW-1:0] LAST = IW'(N_PTS - 1);
    typedef enum logic [1:0] {IDLE, SEND, RECV} state_t;
    state_t          state, state_nx;
    logic [IW-1:0]   idx_i, idx_j;
    logic            irq_en, done, err, busy;
    logic [DW-1:0]   scratch, rd_reg, rd_val;
    logic [2*WL-1:0] in_buf  [N_PTS];
    logic [2*WL-1:0] out_buf [N_PTS];
    logic            aw_go, ar_go, wr_en, rd_en, w_win, r_win;
    logic [1:0]      w_reg, r_reg;
    logic [IW-1:0]   w_k, r_k;
    logic            ctrl_wr, stat_wr, start_wr, abort_wr;
    logic            in_fire, out_fire, in_end, out_end, last_bad;
    logic            unused;
    assign unused   = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr, s_axi.araddr};
    assign aw_go    = s_axi.awvalid & s_axi.wvalid & !s_axi.bvalid & !s_axi.awready;
    assign ar_go    = s_axi.arvalid & !s_axi.rvalid & !s_axi.arready;
    assign wr_en    = s_axi.awready & s_axi.awvalid & s_axi.wvalid;
    assign rd_en    = s_axi.arready & s_axi.arvalid;
    assign w_win    = s_axi.awaddr[AW-1];
    assign r_win    = s_axi.araddr[AW-1];
    assign w_reg    = s_axi.awaddr[3:2];
    assign r_reg    = s_axi.araddr[3:2];
    assign w_k      = s_axi.awaddr[IW+1:2];
    assign r_k      = s_axi.araddr[IW+1:2];
    assign ctrl_wr  = wr_en & !w_win & (w_reg == 2'd0) & s_axi.wstrb[0];
    assign stat_wr  = wr_en & !w_win & (w_reg == 2'd1) & s_axi.wstrb[0];
    assign start_wr = ctrl_wr & s_axi.wdata[0];
    assign abort_wr = ctrl_wr & s_axi.wdata[2];
    assign in_fire  = fft_in_valid & fft_in_ready;
    assign out_fire = fft_out_valid & fft_out_ready;
    assign in_end   = in_fire & (idx_i == LAST);
    assign out_end  = out_fire & (idx_j == LAST);
    assign last_bad = out_fire & (fft_out_last != (idx_j == LAST));
    assign irq      = done & irq_en;
    always_comb begin
        state_nx      = abort_wr                      ? IDLE :
                        (state == IDLE && start_wr)   ? SEND :
                        (state == SEND && in_end)     ? RECV :
                        (state == RECV && out_end)    ? IDLE : state;
        busy          = state != IDLE;
        fft_in_valid  = state == SEND;
        fft_out_ready = state == RECV;
        fft_in_data   = in_buf[idx_i];
        fft_in_last   = fft_in_valid & (idx_i == LAST);
    end
    always_comb begin
        rd_reg = r_reg == 2'd0 ? {{(DW-2){1'b0}}, irq_en, 1'b0} :
                 r_reg == 2'd1 ? {{(DW-3){1'b0}}, err, done, busy} :
                 r_reg == 2'd2 ? DW'(N_PTS) : scratch;
        rd_val = !r_win ? rd_reg : (state == RECV) ? '0 : DW'(out_buf[r_k]);
    end
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= 2'b00;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= 2'b00;
            state         <= IDLE;
            idx_i         <= '0;
            idx_j         <= '0;
            irq_en        <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            scratch       <= '0;
        end else begin
            s_axi.awready <= aw_go;
            s_axi.wready  <= aw_go;
            s_axi.arready <= ar_go;
            if (wr_en) begin
                s_axi.bvalid <= 1'b1;
                s_axi.bresp  <= (w_win & busy) ? 2'b10 : 2'b00;
            end else if (s_axi.bready) s_axi.bvalid <= 1'b0;
            if (rd_en) begin
                s_axi.rvalid <= 1'b1;
                s_axi.rdata  <= rd_val;
                s_axi.rresp  <= (r_win & (state == RECV)) ? 2'b10 : 2'b00;
            end else if (s_axi.rready) s_axi.rvalid <= 1'b0;
            state <= state_nx;
            idx_i <= abort_wr ? '0 : in_fire ? idx_i + 1'b1 : idx_i;
            idx_j <= abort_wr ? '0 : out_fire ? idx_j + 1'b1 : idx_j;
            if (ctrl_wr) irq_en <= s_axi.wdata[1];
            // hardware set takes priority over a same-cycle W1C
            done <= (out_end & !abort_wr) | (done & !(stat_wr & s_axi.wdata[1]));
            err  <= last_bad | (err & !(stat_wr & s_axi.wdata[2]));
            for (int b = 0; b < NB; b++)
                if (wr_en && !w_win && w_reg == 2'd3 && s_axi.wstrb[b])
                    scratch[8*b+:8] <= s_axi.wdata[8*b+:8];
        end
    end
    always_ff @(posedge s_axi_aclk) begin
        for (int b = 0; b < NB; b++)
            if (wr_en && w_win && !busy && s_axi.wstrb[b])
                in_buf[w_k][8*b+:8] <= s_axi.wdata[8*b+:8];
        if (out_fire) out_buf[idx_j] <= fft_out_data;
    end
endmodule

// File: tb/tb_fft_axil_frame_ctrl.sv
// tb_fft_axil_frame_ctrl: directed checks of the FFT AXI4-Lite frame controller with an echoing core model
module tb_fft_axil_frame_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fft_in_valid, fft_in_ready, fft_in_last;
    logic        fft_out_valid, fft_out_ready, fft_out_last, irq;
    logic [31:0] fft_in_data, fft_out_data;
    int          checks = 0, failures = 0;
    int          cyc = 0, beats = 0, beat_limit = 1000, vcyc = 0, out_cnt = 0, last_at = 15;
    bit          rnd = 1'b0, echo_en = 1'b1, out_pend = 1'b0;
    logic [31:0] log_d[$];
    logic        log_l[$];
    logic [31:0] qd[$];
    int          due[$];
    always #5 clk = ~clk;
    fft_axil_frame_ctrl_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(7)) bus ();
    fft_axil_frame_ctrl #(.WL(16), .N_PTS(16), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(7)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi         (bus),
        .fft_in_valid  (fft_in_valid),
        .fft_in_ready  (fft_in_ready),
        .fft_in_data   (fft_in_data),
        .fft_in_last   (fft_in_last),
        .fft_out_valid (fft_out_valid),
        .fft_out_ready (fft_out_ready),
        .fft_out_data  (fft_out_data),
        .fft_out_last  (fft_out_last),
        .irq           (irq)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic axi_wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        while (!bus.awready && n < 20) begin @(negedge clk); n++; end
        chk("aw_handshake", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("bvalid", 32'(bus.bvalid), 32'd1);
        resp = bus.bresp;
    endtask
    task automatic axi_rd(input logic [6:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        bus.araddr = a; bus.arvalid = 1'b1;
        while (!bus.arready && n < 20) begin @(negedge clk); n++; end
        chk("ar_handshake", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        chk("rvalid", 32'(bus.rvalid), 32'd1);
        d = bus.rdata; resp = bus.rresp;
    endtask
    task automatic wait_irq(input string tag);
        int n = 0;
        while (!irq && n < 400) begin @(negedge clk); n++; end
        chk(tag, 32'(irq), 32'd1);
    endtask
    initial begin
        fft_in_ready = 1'b0; fft_out_valid = 1'b0; fft_out_data = '0; fft_out_last = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (out_pend) begin
                void'(qd.pop_front()); void'(due.pop_front());
                out_cnt = (out_cnt + 1) % 16;
            end
            fft_in_ready = (beats < beat_limit) && (!rnd || $urandom_range(0, 1) == 1);
            if (fft_in_valid) vcyc++;
            if (fft_in_valid && fft_in_ready) begin
                beats++;
                log_d.push_back(fft_in_data);
                log_l.push_back(fft_in_last);
                if (echo_en) begin
                    qd.push_back({16'd0 - fft_in_data[31:16], 16'd0 - fft_in_data[15:0]});
                    due.push_back(cyc + 5);
                end
            end
            if (qd.size() > 0 && due[0] <= cyc) begin
                fft_out_valid = 1'b1; fft_out_data = qd[0]; fft_out_last = (out_cnt == last_at);
            end else begin
                fft_out_valid = 1'b0; fft_out_last = 1'b0;
            end
            out_pend = fft_out_valid && fft_out_ready;
        end
    end
    initial begin
        logic [31:0] d;
        logic [1:0]  r, racc;
        int          base, v0;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b1; bus.araddr = '0; bus.arprot = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_in_valid", 32'(fft_in_valid), 32'd0);
        chk("rst_out_ready", 32'(fft_out_ready), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        axi_rd(7'h00, d, r); chk("rst_ctrl", d, 32'd0);
        axi_rd(7'h04, d, r); chk("rst_status", d, 32'd0);
        axi_rd(7'h0C, d, r); chk("rst_scratch", d, 32'd0);
        axi_wr(7'h0C, 32'hA5A5_5A5A, 4'b0011, r); chk("scratch_bresp", 32'(r), 32'd0);
        axi_rd(7'h0C, d, r); chk("scratch_rd", d, 32'h0000_5A5A); chk("scratch_rresp", 32'(r), 32'd0);
        axi_rd(7'h08, d, r); chk("npts", d, 32'd16);
        racc = 2'b00;
        for (int k = 0; k < 16; k++) begin
            axi_wr(7'h40 + 7'(4 * k), 32'(k), 4'hF, r);
            racc |= r;
        end
        chk("load_bresp", 32'(racc), 32'd0);
        axi_wr(7'h00, 32'h2, 4'hF, r);
        base = log_d.size(); v0 = vcyc;
        axi_wr(7'h00, 32'h3, 4'hF, r);
        chk("start_valid_next", 32'(fft_in_valid), 32'd1);
        wait_irq("frame_done");
        chk("frame_beats", 32'(log_d.size() - base), 32'd16);
        chk("send_cycles", 32'(vcyc - v0), 32'd16);
        for (int k = 0; k < 16; k++) begin
            chk("frame_sample", log_d[base + k], 32'(k));
            chk("frame_last", 32'(log_l[base + k]), 32'(k == 15));
        end
        axi_rd(7'h04, d, r); chk("frame_status", d, 32'h2);
        axi_rd(7'h40, d, r); chk("win0", d, 32'h0000_0000);
        axi_rd(7'h44, d, r); chk("win1", d, 32'h0000_FFFF); chk("win_rresp", 32'(r), 32'd0);
        axi_rd(7'h7C, d, r); chk("win15", d, 32'h0000_FFF1);
        axi_wr(7'h04, 32'h6, 4'hF, r);
        axi_rd(7'h04, d, r); chk("w1c_status", d, 32'h0);
        chk("w1c_irq", 32'(irq), 32'd0);
        rnd = 1'b1;
        base = log_d.size();
        axi_wr(7'h00, 32'h3, 4'hF, r);
        wait_irq("bp_done");
        rnd = 1'b0;
        chk("bp_beats", 32'(log_d.size() - base), 32'd16);
        for (int k = 0; k < 16; k++) chk("bp_order", log_d[base + k], 32'(k));
        axi_rd(7'h68, d, r); chk("bp_win10", d, 32'h0000_FFF6);
        axi_wr(7'h04, 32'h6, 4'hF, r);
        last_at = 7;
        base = log_d.size();
        axi_wr(7'h00, 32'h3, 4'hF, r);
        axi_wr(7'h4C, 32'h0000_DEAD, 4'hF, r); chk("busy_win_bresp", 32'(r), 32'd2);
        wait_irq("err_done");
        axi_rd(7'h04, d, r); chk("err_status", d, 32'h6);
        axi_rd(7'h7C, d, r); chk("err_win15", d, 32'h0000_FFF1);
        last_at = 15;
        axi_wr(7'h04, 32'h6, 4'hF, r);
        axi_rd(7'h04, d, r); chk("err_w1c", d, 32'h0);
        chk("err_w1c_irq", 32'(irq), 32'd0);
        echo_en = 1'b0;
        beat_limit = beats + 4;
        base = log_d.size();
        axi_wr(7'h00, 32'h3, 4'hF, r);
        repeat (10) @(negedge clk);
        chk("abort_beats", 32'(log_d.size() - base), 32'd4);
        chk("abort_stalled", 32'(fft_in_valid), 32'd1);
        axi_wr(7'h00, 32'h6, 4'hF, r);
        chk("abort_idle", 32'(fft_in_valid), 32'd0);
        axi_rd(7'h04, d, r); chk("abort_status", d, 32'h0);
        beat_limit = 1000; echo_en = 1'b1;
        base = log_d.size();
        axi_wr(7'h00, 32'h3, 4'hF, r);
        wait_irq("restart_done");
        chk("restart_beats", 32'(log_d.size() - base), 32'd16);
        chk("restart_s0", log_d[base], 32'd0);
        chk("restart_s3_kept", log_d[base + 3], 32'd3);
        axi_wr(7'h04, 32'h6, 4'hF, r);
        echo_en = 1'b0;
        axi_wr(7'h00, 32'h3, 4'hF, r);
        begin
            int n = 0;
            while (!fft_out_ready && n < 100) begin @(negedge clk); n++; end
        end
        chk("recv_reached", 32'(fft_out_ready), 32'd1);
        axi_rd(7'h44, d, r); chk("recv_win_data", d, 32'h0); chk("recv_win_rresp", 32'(r), 32'd2);
        axi_rd(7'h04, d, r); chk("recv_status", d, 32'h1); chk("recv_reg_rresp", 32'(r), 32'd0);
        axi_wr(7'h00, 32'h6, 4'hF, r);
        chk("recv_abort", 32'(fft_out_ready), 32'd0);
        beat_limit = beats;
        axi_wr(7'h00, 32'h3, 4'hF, r);
        chk("pre_rst_valid", 32'(fft_in_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(fft_in_valid), 32'd0);
        chk("async_rst_irq", 32'(irq), 32'd0);
        chk("async_rst_bvalid", 32'(bus.bvalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beat_limit = 1000;
        axi_rd(7'h04, d, r); chk("post_rst_status", d, 32'h0);
        axi_rd(7'h00, d, r); chk("post_rst_ctrl", d, 32'h0);
        axi_rd(7'h0C, d, r); chk("post_rst_scratch", d, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
